// File: rtl/key_pkg.sv
// Shared types and key-code constants for the keypad command controller.
package key_pkg;

  localparam int unsigned DATA_W = 20;
  localparam int unsigned MAC_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_SEND  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam logic [3:0] KEY_COMMIT_FRE = 4'hA;
  localparam logic [3:0] KEY_COMMIT_PHA = 4'hB;
  localparam logic [3:0] KEY_BKSP       = 4'hC;
  localparam logic [3:0] KEY_CLR        = 4'hE;

  // Configuration write payload: target select plus value.
  typedef struct packed {
    logic              sel;
    logic [DATA_W-1:0] data;
  } cfg_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/key_timer.sv
// Idle timeout counter: counts while enabled, flags the terminal cycle.
module key_timer #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next count: held at zero when cleared or idle, wraps at the terminal value.
  always_comb begin
    cnt_nxt = cnt;
    if (clr || !en) begin
      cnt_nxt = '0;
    end else if (cnt == TERM) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Counter and registered terminal flag (high exactly while cnt sits at TERM).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      expire <= (cnt_nxt == TERM);
    end
  end

endmodule

// File: rtl/key_cmd_ctrl.sv
// Keypad entry controller: builds a decimal value and commits it to the DDS as frequency or phase.
module key_cmd_ctrl
  import key_pkg::*;
#(
  parameter logic [DATA_W-1:0] FRE_MAX     = 20'd999999,
  parameter logic [DATA_W-1:0] PHA_MAX     = 20'd359,
  parameter int unsigned       MAX_DIGITS  = 6,
  parameter int unsigned       TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic              cfg_valid,
  input  logic              cfg_ready,
  output logic              cfg_sel,
  output logic [DATA_W-1:0] cfg_data,
  output logic [DATA_W-1:0] fre_out,
  output logic [DATA_W-1:0] pha_out,
  output logic [DATA_W-1:0] smg_out,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  state_e            state, state_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  cfg_t              cfg_q, cfg_nxt;
  logic [DATA_W-1:0] fre_nxt, pha_nxt;

  logic timer_clr;
  logic timer_en;
  logic timer_expire;

  // Timer runs only in ENTRY and restarts on any key or on leaving/entering ENTRY.
  assign timer_en  = (state == ST_ENTRY);
  assign timer_clr = key_valid || (state != ST_ENTRY);

  key_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // Next-state and datapath update; keys take priority over the timeout.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    cfg_nxt   = cfg_q;
    fre_nxt   = fre_out;
    pha_nxt   = pha_out;

    case (state)
      ST_IDLE, ST_ENTRY: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            if (count < CNT_W'(MAX_DIGITS)) begin
              acc_nxt   = DATA_W'(MAC_W'(acc) * MAC_W'(10) + MAC_W'(key_code));
              count_nxt = count + CNT_W'(1);
              state_nxt = ST_ENTRY;
            end
          end else begin
            case (key_code)
              KEY_BKSP: begin
                if (count != '0) begin
                  acc_nxt   = acc / DATA_W'(10);
                  count_nxt = count - CNT_W'(1);
                  state_nxt = (count == CNT_W'(1)) ? ST_IDLE : ST_ENTRY;
                end
              end
              KEY_CLR: begin
                acc_nxt   = '0;
                count_nxt = '0;
                state_nxt = ST_IDLE;
              end
              KEY_COMMIT_FRE: begin
                if (state == ST_ENTRY) begin
                  if (acc <= FRE_MAX) begin
                    state_nxt    = ST_SEND;
                    cfg_nxt.sel  = 1'b0;
                    cfg_nxt.data = acc;
                  end else begin
                    state_nxt = ST_ERROR;
                  end
                end
              end
              KEY_COMMIT_PHA: begin
                if (state == ST_ENTRY) begin
                  if (acc <= PHA_MAX) begin
                    state_nxt    = ST_SEND;
                    cfg_nxt.sel  = 1'b1;
                    cfg_nxt.data = acc;
                  end else begin
                    state_nxt = ST_ERROR;
                  end
                end
              end
              default: ;
            endcase
          end
        end else if ((state == ST_ENTRY) && timer_expire) begin
          acc_nxt   = '0;
          count_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (cfg_valid && cfg_ready) begin
          if (cfg_q.sel) begin
            pha_nxt = cfg_q.data;
          end else begin
            fre_nxt = cfg_q.data;
          end
          acc_nxt   = '0;
          count_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end

      ST_ERROR: begin
        if (key_valid) begin
          acc_nxt   = '0;
          count_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        acc_nxt   = '0;
        count_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, entry buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      count     <= '0;
      cfg_q     <= '0;
      cfg_valid <= 1'b0;
      fre_out   <= '0;
      pha_out   <= '0;
      smg_out   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      count     <= count_nxt;
      cfg_q     <= cfg_nxt;
      cfg_valid <= (state_nxt == ST_SEND);
      fre_out   <= fre_nxt;
      pha_out   <= pha_nxt;
      smg_out   <= acc_nxt;
      err       <= (state_nxt == ST_ERROR);
    end
  end

  assign cfg_sel  = cfg_q.sel;
  assign cfg_data = cfg_q.data;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Self-checking bench for key_cmd_ctrl: vector table plus multi-cycle corner sequences.
module tb_key_cmd_ctrl;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_sel;
  logic [19:0] cfg_data;
  logic [19:0] fre_out;
  logic [19:0] pha_out;
  logic [19:0] smg_out;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  key;
    logic        push;
    logic        sel;
    logic [19:0] wdata;
    logic [19:0] smg;
    logic        er;
    logic [19:0] fre;
    logic [19:0] pha;
  } vec_t;

  vec_t        vecs[$];
  logic [20:0] exp_q[$];

  key_cmd_ctrl #(
    .FRE_MAX     (20'd999999),
    .PHA_MAX     (20'd359),
    .MAX_DIGITS  (6),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .fre_out   (fre_out),
    .pha_out   (pha_out),
    .smg_out   (smg_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Drive one key strobe for exactly one clock, changing inputs just after posedge.
  task automatic press(input logic [3:0] k);
    @(posedge clk);
    #2;
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    #2;
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic add(input logic [3:0] k, input logic p, input logic s, input logic [19:0] wd,
                     input logic [19:0] sm, input logic e, input logic [19:0] f, input logic [19:0] ph);
    vec_t v;
    v.key = k; v.push = p; v.sel = s; v.wdata = wd;
    v.smg = sm; v.er = e; v.fre = f; v.pha = ph;
    vecs.push_back(v);
  endtask

  initial begin
    int vcnt;
    logic [20:0] e;

    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    cfg_ready = 1'b1;

    // Watchdog
    fork
      begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Scoreboard: every accepted write is popped from the expectation queue.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && cfg_valid && cfg_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL write_unexpected: got sel=%0d data=%0d, required no write", cfg_sel, cfg_data);
          end else begin
            e = exp_q.pop_front();
            check("write_payload", 32'({cfg_sel, cfg_data}), 32'(e));
          end
        end
      end
    join_none

    // Table: digits, commits, overflow hold, backspace, clear, ignored keys, error.
    add(4'h1, 0, 0, 0,      1,      0, 0,      0);
    add(4'h2, 0, 0, 0,      12,     0, 0,      0);
    add(4'h3, 0, 0, 0,      123,    0, 0,      0);
    add(4'h4, 0, 0, 0,      1234,   0, 0,      0);
    add(4'hA, 1, 0, 1234,   0,      0, 1234,   0);
    add(4'h9, 0, 0, 0,      9,      0, 1234,   0);
    add(4'h9, 0, 0, 0,      99,     0, 1234,   0);
    add(4'h9, 0, 0, 0,      999,    0, 1234,   0);
    add(4'h9, 0, 0, 0,      9999,   0, 1234,   0);
    add(4'h9, 0, 0, 0,      99999,  0, 1234,   0);
    add(4'h9, 0, 0, 0,      999999, 0, 1234,   0);
    add(4'h9, 0, 0, 0,      999999, 0, 1234,   0);
    add(4'hA, 1, 0, 999999, 0,      0, 999999, 0);
    add(4'h5, 0, 0, 0,      5,      0, 999999, 0);
    add(4'hC, 0, 0, 0,      0,      0, 999999, 0);
    add(4'hC, 0, 0, 0,      0,      0, 999999, 0);
    add(4'h7, 0, 0, 0,      7,      0, 999999, 0);
    add(4'hE, 0, 0, 0,      0,      0, 999999, 0);
    add(4'hA, 0, 0, 0,      0,      0, 999999, 0);
    add(4'hB, 0, 0, 0,      0,      0, 999999, 0);
    add(4'hD, 0, 0, 0,      0,      0, 999999, 0);
    add(4'hF, 0, 0, 0,      0,      0, 999999, 0);
    add(4'h2, 0, 0, 0,      2,      0, 999999, 0);
    add(4'hD, 0, 0, 0,      2,      0, 999999, 0);
    add(4'hC, 0, 0, 0,      0,      0, 999999, 0);
    add(4'h4, 0, 0, 0,      4,      0, 999999, 0);
    add(4'h5, 0, 0, 0,      45,     0, 999999, 0);
    add(4'hB, 1, 1, 45,     0,      0, 999999, 45);
    add(4'h3, 0, 0, 0,      3,      0, 999999, 45);
    add(4'h6, 0, 0, 0,      36,     0, 999999, 45);
    add(4'h0, 0, 0, 0,      360,    0, 999999, 45);
    add(4'hB, 0, 0, 0,      360,    1, 999999, 45);
    add(4'h5, 0, 0, 0,      0,      0, 999999, 45);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst cfg_valid", 32'(cfg_valid), 32'd0);
    check("rst cfg_sel",   32'(cfg_sel),   32'd0);
    check("rst cfg_data",  32'(cfg_data),  32'd0);
    check("rst fre_out",   32'(fre_out),   32'd0);
    check("rst pha_out",   32'(pha_out),   32'd0);
    check("rst smg_out",   32'(smg_out),   32'd0);
    check("rst err",       32'(err),       32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].push) exp_q.push_back({vecs[i].sel, vecs[i].wdata});
      press(vecs[i].key);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d smg", i), 32'(smg_out), 32'(vecs[i].smg));
      check($sformatf("v%0d err", i), 32'(err),     32'(vecs[i].er));
      check($sformatf("v%0d fre", i), 32'(fre_out), 32'(vecs[i].fre));
      check($sformatf("v%0d pha", i), 32'(pha_out), 32'(vecs[i].pha));
    end

    // Phase commit held off by cfg_ready low for 5 cycles: valid high 6 cycles, data stable.
    cfg_ready = 1'b0;
    press(4'h3);
    press(4'h5);
    press(4'h9);
    exp_q.push_back({1'b1, 20'd359});
    press(4'hB);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #2;
      end
      cfg_ready = (i >= 5);
      @(negedge clk);
      if (cfg_valid) begin
        vcnt++;
        check($sformatf("hold data c%0d", i), 32'({cfg_sel, cfg_data}), 32'({1'b1, 20'd359}));
      end
    end
    check("hold valid_cycles", 32'(vcnt), 32'd6);
    check("hold pha_out", 32'(pha_out), 32'd359);
    check("hold fre_out", 32'(fre_out), 32'd999999);

    // Timeout abandons the entry after TIMEOUT_CYC idle cycles in ENTRY.
    press(4'h4);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("tmo before", 32'(smg_out), 32'd4);
    @(posedge clk);
    @(negedge clk);
    check("tmo after", 32'(smg_out), 32'd0);
    press(4'hA);
    @(posedge clk);
    @(negedge clk);
    check("tmo idle_commit_ignored", 32'(fre_out), 32'd999999);

    // Key on the terminal cycle wins over the timeout.
    press(4'h4);
    repeat (14) @(posedge clk);
    press(4'h7);
    @(negedge clk);
    check("tmo key_wins", 32'(smg_out), 32'd47);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("tmo restarted", 32'(smg_out), 32'd47);
    press(4'hE);
    @(negedge clk);
    check("tmo clear", 32'(smg_out), 32'd0);

    // Reset in the middle of a stalled write.
    cfg_ready = 1'b0;
    press(4'h1);
    press(4'h2);
    press(4'hA);
    @(negedge clk);
    check("rsend valid_before", 32'(cfg_valid), 32'd1);
    check("rsend data_before",  32'(cfg_data),  32'd12);
    #2;
    rst_n = 1'b0;
    #1;
    check("rsend cfg_valid", 32'(cfg_valid), 32'd0);
    check("rsend cfg_data",  32'(cfg_data),  32'd0);
    check("rsend fre_out",   32'(fre_out),   32'd0);
    check("rsend pha_out",   32'(pha_out),   32'd0);
    check("rsend smg_out",   32'(smg_out),   32'd0);
    check("rsend err",       32'(err),       32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    cfg_ready = 1'b1;
    press(4'h8);
    exp_q.push_back({1'b0, 20'd8});
    press(4'hA);
    @(posedge clk);
    @(negedge clk);
    check("post_rst fre_out", 32'(fre_out), 32'd8);
    check("post_rst smg_out", 32'(smg_out), 32'd0);
    check("post_rst pha_out", 32'(pha_out), 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_cmd_ctrl.md
KEY_CMD_CTRL -- requirements
Module: key_cmd_ctrl

Interface
REQ-001 Parameter FRE_MAX, default 20'd999999, is the largest legal frequency value.
REQ-002 Parameter PHA_MAX, default 20'd359, is the largest legal phase value.
REQ-003 Parameter MAX_DIGITS, default 6, is the digit-count limit of the entry buffer.
REQ-004 Parameter TIMEOUT_CYC, default 50_000_000, is the idle cycles before an entry is abandoned.
REQ-005 Port clk, input, 1: the single clock; all logic is on posedge clk.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port key_valid, input, 1: one-cycle strobe; key_code is valid this cycle.
REQ-008 Port key_code, input, 4: 0-9 digit; A commit frequency; B commit phase; C backspace; E clear; D and F ignored.
REQ-009 Port cfg_valid, output, 1: configuration write request to the DDS datapath.
REQ-010 Port cfg_ready, input, 1: the datapath accepts the write when cfg_valid and cfg_ready are both high.
REQ-011 Port cfg_sel, output, 1: 0 selects the frequency write, 1 selects the phase write.
REQ-012 Port cfg_data, output, 20: the value being written.
REQ-013 Port fre_out, output, 20: last accepted frequency.
REQ-014 Port pha_out, output, 20: last accepted phase.
REQ-015 Port smg_out, output, 20: the current entry buffer, driven to the display.
REQ-016 Port err, output, 1: high while in ERROR.

Function
REQ-017 The FSM SHALL have the states IDLE, ENTRY, SEND and ERROR.
REQ-018 In IDLE or ENTRY, a digit key with digit count < MAX_DIGITS: acc <= acc*10+digit, count+1, state -> ENTRY, all in one cycle.
REQ-019 When a digit arrives with count == MAX_DIGITS: acc and count hold, with no error.
REQ-020 Multiply-add is computed at 24 bits and stored at 20 bits; MAX_DIGITS=6 guarantees no truncation.
REQ-021 Key C (backspace): acc <= acc/10, count-1; at count 0 it has no effect; when count reaches 0 -> IDLE.
REQ-022 Key E: acc <= 0, count <= 0 -> IDLE.
REQ-023 Key A in ENTRY: if acc <= FRE_MAX -> SEND with cfg_sel=0; otherwise -> ERROR.
REQ-024 Key B in ENTRY: if acc <= PHA_MAX -> SEND with cfg_sel=1; otherwise -> ERROR.
REQ-025 Key A or B in IDLE (empty buffer) SHALL be ignored.
REQ-026 SEND: cfg_valid=1 from the first SEND cycle, with cfg_data=acc and cfg_sel stable until the handshake.
REQ-027 A handshake in SEND SHALL, in the same edge, update fre_out or pha_out, clear acc and count, deassert cfg_valid next cycle, and move -> IDLE.
REQ-028 If cfg_ready is already high on SEND entry, SEND SHALL last exactly one cycle.
REQ-029 key_valid during SEND SHALL be dropped, not queued.
REQ-030 ERROR: err=1 and acc is held for display; the next key_valid (any code) clears acc and count, err=0 -> IDLE, and that key is otherwise discarded.
REQ-031 Timeout counter: reset on every key_valid and on every ENTRY entry; counts only in ENTRY; at TIMEOUT_CYC-1 it clears acc and count -> IDLE.
REQ-032 A key_valid in the same cycle as the timeout terminal count SHALL win: the key is processed and the counter resets.
REQ-033 smg_out SHALL equal acc registered; there is no combinational path from key_code to any output.
REQ-034 fre_out and pha_out SHALL change only on a handshake.

Reset
REQ-035 rst_n low SHALL asynchronously force IDLE, acc=0, count=0, timer=0, cfg_valid=0, cfg_sel=0, cfg_data=0, fre_out=0, pha_out=0, smg_out=0, err=0.
REQ-036 Reset during SEND SHALL abandon the write with cfg_valid low immediately; fre_out and pha_out read 0.

Structure
REQ-037 Package key_pkg SHALL hold the state enum and the key-code constants (KEY_COMMIT_FRE=4'hA, KEY_COMMIT_PHA=4'hB, KEY_BKSP=4'hC, KEY_CLR=4'hE).
REQ-038 The timeout counter SHALL be a sub-module key_timer (parameter TIMEOUT_CYC; ports clk, rst_n, clr, en, expire).

Verification
REQ-039 Keys 1,2,3,4,A with cfg_ready=1 -> cfg_valid one cycle, cfg_sel=0, cfg_data=1234; fre_out=1234; smg_out=0.
REQ-040 Keys 3,6,0,B with cfg_ready low 5 cycles -> cfg_valid high 6 cycles with stable data 360; this exceeds PHA_MAX, so the bench uses 3,5,9,B, expects pha_out=359, and separately 3,6,0,B -> err=1, pha_out unchanged.
REQ-041 Keys 9 ×7 -> smg_out=999999 after the sixth digit, unchanged after the seventh; A -> fre_out=999999.
REQ-042 Keys 5,C,C,7 -> smg_out 5,0,0,7; state is IDLE after the first C.
REQ-043 Key 4 then no keys for TIMEOUT_CYC cycles (bench sets TIMEOUT_CYC=16) -> smg_out=0 and state IDLE; a key landing exactly on the terminal cycle is processed.
REQ-044 Assert rst_n mid-SEND -> all outputs are 0 asynchronously, and the next entry works normally.
